// File: rtl/agv_pkg.sv
// Shared AGV types and constants: obstacle FSM states, motor stop pattern,
// and a counter-width helper.
package agv_pkg;

  typedef enum logic [1:0] {
    DRIVE   = 2'd0,
    STOP    = 2'd1,
    CLEAR   = 2'd2,
    BLOCKED = 2'd3
  } obst_state_t;

  localparam logic [3:0]  MOTOR_STOP = 4'b0000;
  localparam int unsigned CLK_HZ     = 50_000_000;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/obstacle_debounce.sv
// Samples the raw obstacle flag once per measurement period and flips the
// debounced state only after DEBOUNCE_CNT consecutive differing samples.
module obstacle_debounce
  import agv_pkg::*;
#(
  parameter int unsigned SAMPLE_TICKS = 1_900_000,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic obj_det,
  output logic obstacle
);

  localparam int unsigned TICK_W = cnt_w(SAMPLE_TICKS);
  localparam int unsigned RUN_W  = cnt_w(DEBOUNCE_CNT);

  logic [TICK_W-1:0] r_tick_cnt;
  logic [RUN_W-1:0]  r_run_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_W'(SAMPLE_TICKS - 1));

  // Run counter holds DEBOUNCE_CNT-1 at most; the next differing sample toggles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_run_cnt  <= '0;
      obstacle   <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
      if (w_tick) begin
        if (obj_det == obstacle) begin
          r_run_cnt <= '0;
        end else if (r_run_cnt == RUN_W'(DEBOUNCE_CNT - 1)) begin
          obstacle  <= ~obstacle;
          r_run_cnt <= '0;
        end else begin
          r_run_cnt <= r_run_cnt + RUN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/obstacle_stop_ctrl.sv
// Safety gate between the drive command and the H-bridge: stops on a debounced
// obstacle, resumes after a clear hold-off, and latches a blocked-timeout flag.
module obstacle_stop_ctrl
  import agv_pkg::*;
#(
  parameter int unsigned SAMPLE_TICKS  = 1_900_000,
  parameter int unsigned DEBOUNCE_CNT  = 3,
  parameter int unsigned HOLD_TICKS    = 25_000_000,
  parameter int unsigned BLOCK_TIMEOUT = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       obj_det,
  input  logic [3:0] motor_in,
  input  logic       blocked_ack,
  output logic [3:0] motor_out,
  output logic       obstacle,
  output logic       stopped,
  output logic       blocked
);

  localparam int unsigned STOP_W = cnt_w(BLOCK_TIMEOUT);
  localparam int unsigned HOLD_W = cnt_w(HOLD_TICKS);

  obst_state_t       r_state;
  obst_state_t       w_state_nxt;
  logic [STOP_W-1:0] r_stop_cnt;
  logic [STOP_W-1:0] w_stop_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;

  obstacle_debounce #(
    .SAMPLE_TICKS (SAMPLE_TICKS),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .obj_det  (obj_det),
    .obstacle (obstacle)
  );

  // Outputs follow the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_stop_cnt <= '0;
      r_hold_cnt <= '0;
      motor_out  <= MOTOR_STOP;
      stopped    <= 1'b1;
      blocked    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      motor_out  <= (w_state_nxt == DRIVE) ? motor_in : MOTOR_STOP;
      stopped    <= (w_state_nxt != DRIVE);
      blocked    <= (w_state_nxt == BLOCKED);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_stop_cnt_nxt = r_stop_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      DRIVE: begin
        if (obstacle) begin
          w_state_nxt    = STOP;
          w_stop_cnt_nxt = '0;
        end
      end
      STOP: begin
        w_stop_cnt_nxt = (r_stop_cnt == '1) ? r_stop_cnt : r_stop_cnt + STOP_W'(1);
        if (!obstacle) begin
          w_state_nxt    = CLEAR;
          w_hold_cnt_nxt = '0;
        end else if (r_stop_cnt == STOP_W'(BLOCK_TIMEOUT - 1)) begin
          w_state_nxt = BLOCKED;
        end
      end
      CLEAR: begin
        // Stop time is kept, so flicker between STOP and CLEAR still times out.
        w_hold_cnt_nxt = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);
        if (obstacle) begin
          w_state_nxt = STOP;
        end else if (r_hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
          w_state_nxt = DRIVE;
        end
      end
      BLOCKED: begin
        if (blocked_ack) begin
          if (obstacle) begin
            w_state_nxt    = STOP;
            w_stop_cnt_nxt = '0;
          end else begin
            w_state_nxt    = CLEAR;
            w_hold_cnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_obstacle_stop_ctrl.sv
// Directed bench for obstacle_stop_ctrl with short periods; a second instance
// with a longer hold-off exercises STOP/CLEAR flicker and time accumulation.
module tb_obstacle_stop_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, obj_det, blocked_ack;
  logic [3:0] motor_in;
  logic [3:0] motor_out;
  logic       obstacle, stopped, blocked;

  logic       rst2_n, obj2, ack2;
  logic [3:0] motor2;
  logic       obstacle2, stopped2, blocked2;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;

  obstacle_stop_ctrl #(
    .SAMPLE_TICKS (10), .DEBOUNCE_CNT (3), .HOLD_TICKS (20), .BLOCK_TIMEOUT (100)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .obj_det (obj_det), .motor_in (motor_in),
    .blocked_ack (blocked_ack), .motor_out (motor_out), .obstacle (obstacle),
    .stopped (stopped), .blocked (blocked)
  );

  obstacle_stop_ctrl #(
    .SAMPLE_TICKS (10), .DEBOUNCE_CNT (3), .HOLD_TICKS (40), .BLOCK_TIMEOUT (100)
  ) u_dut_flk (
    .clk (clk), .rst_n (rst2_n), .obj_det (obj2), .motor_in (motor_in),
    .blocked_ack (ack2), .motor_out (motor2), .obstacle (obstacle2),
    .stopped (stopped2), .blocked (blocked2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Advance to just after posedge number t (counted from reset release), sampling at negedge.
  task automatic adv_to(input int unsigned t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; obj_det = 1'b0; obj2 = 1'b0;
    blocked_ack = 1'b0; ack2 = 1'b0; motor_in = 4'b1010;
    repeat (3) @(negedge clk);
    check("rst_motor", 32'(motor_out), 32'h0);
    check("rst_stopped", 32'(stopped), 32'h1);
    check("rst_blocked", 32'(blocked), 32'h0);
    check("rst_obstacle", 32'(obstacle), 32'h0);
    rst_n = 1'b1; rst2_n = 1'b1; cyc = 0;

    // start-up hold-off: DRIVE on edge 20
    for (int n = 1; n <= 19; n++) begin
      adv_to(n);
      check("start_stopped", 32'(stopped), 32'h1);
      check("start_motor", 32'(motor_out), 32'h0);
    end
    adv_to(20);
    check("drive_stopped", 32'(stopped), 32'h0);
    check("drive_motor", 32'(motor_out), 32'ha);

    // glitch across ticks 30 and 40 only
    obj_det = 1'b1;
    for (int n = 21; n <= 60; n++) begin
      adv_to(n);
      check("glitch_obstacle", 32'(obstacle), 32'h0);
      check("glitch_motor", 32'(motor_out), 32'ha);
      if (n == 40) obj_det = 1'b0;
    end

    // obstacle stop: ticks 70, 80, 90
    obj_det = 1'b1;
    for (int n = 61; n <= 89; n++) begin
      adv_to(n);
      check("pre_obstacle", 32'(obstacle), 32'h0);
    end
    adv_to(90);
    check("obst_rise", 32'(obstacle), 32'h1);
    check("obst_motor_still", 32'(motor_out), 32'ha);
    check("obst_stopped_still", 32'(stopped), 32'h0);
    adv_to(91);
    check("stop_motor", 32'(motor_out), 32'h0);
    check("stop_stopped", 32'(stopped), 32'h1);

    // clear and resume: obstacle falls at 120, drive at 141
    obj_det = 1'b0;
    adv_to(119);
    check("clear_obst_hold", 32'(obstacle), 32'h1);
    adv_to(120);
    check("clear_obst_fall", 32'(obstacle), 32'h0);
    check("clear_stopped", 32'(stopped), 32'h1);
    adv_to(140);
    check("resume_early_motor", 32'(motor_out), 32'h0);
    check("resume_early_stopped", 32'(stopped), 32'h1);
    adv_to(141);
    check("resume_motor", 32'(motor_out), 32'ha);
    check("resume_stopped", 32'(stopped), 32'h0);

    // blocked timeout: STOP at 171, BLOCKED at 271
    obj_det = 1'b1;
    adv_to(170);
    check("blk_obst", 32'(obstacle), 32'h1);
    adv_to(171);
    check("blk_stopped", 32'(stopped), 32'h1);
    adv_to(270);
    check("blk_early", 32'(blocked), 32'h0);
    adv_to(271);
    check("blk_set", 32'(blocked), 32'h1);
    check("blk_motor", 32'(motor_out), 32'h0);
    check("blk_stopped2", 32'(stopped), 32'h1);
    adv_to(275);
    blocked_ack = 1'b1;
    adv_to(276);
    blocked_ack = 1'b0;
    check("ack_obst_blocked", 32'(blocked), 32'h0);
    check("ack_obst_stopped", 32'(stopped), 32'h1);
    adv_to(375);
    check("reblk_early", 32'(blocked), 32'h0);
    adv_to(376);
    check("reblk_set", 32'(blocked), 32'h1);

    // path clears while blocked; ack moves to CLEAR (drive 20 edges later)
    obj_det = 1'b0;
    adv_to(400);
    check("blk_clear_obst", 32'(obstacle), 32'h0);
    check("blk_stays", 32'(blocked), 32'h1);
    adv_to(405);
    blocked_ack = 1'b1;
    adv_to(406);
    blocked_ack = 1'b0;
    check("ack_clear_blocked", 32'(blocked), 32'h0);
    check("ack_clear_stopped", 32'(stopped), 32'h1);
    adv_to(425);
    check("ack_clear_early", 32'(motor_out), 32'h0);
    adv_to(426);
    check("ack_clear_drive", 32'(motor_out), 32'ha);
    check("ack_clear_stopped2", 32'(stopped), 32'h0);

    // ack outside BLOCKED is ignored
    adv_to(430);
    blocked_ack = 1'b1;
    adv_to(431);
    blocked_ack = 1'b0;
    check("stray_ack_motor", 32'(motor_out), 32'ha);
    check("stray_ack_blocked", 32'(blocked), 32'h0);

    // reset while BLOCKED with obstacle present
    obj_det = 1'b1;
    adv_to(460);
    check("r6_obst", 32'(obstacle), 32'h1);
    adv_to(561);
    check("r6_blocked", 32'(blocked), 32'h1);
    adv_to(565);
    rst_n = 1'b0;
    adv_to(566);
    check("r6_rst_blocked", 32'(blocked), 32'h0);
    check("r6_rst_obstacle", 32'(obstacle), 32'h0);
    check("r6_rst_motor", 32'(motor_out), 32'h0);
    check("r6_rst_stopped", 32'(stopped), 32'h1);
    rst_n = 1'b1;
    obj_det = 1'b0;
    adv_to(585);
    check("r6_clear_stopped", 32'(stopped), 32'h1);
    adv_to(586);
    check("r6_drive_motor", 32'(motor_out), 32'ha);
    check("r6_drive_stopped", 32'(stopped), 32'h0);

    // flicker on long-hold instance: STOP 631, CLEAR 661, STOP 691, BLOCKED 761
    adv_to(600);
    check("flk_drive", 32'(motor2), 32'ha);
    obj2 = 1'b1;
    adv_to(630);
    check("flk_obst1", 32'(obstacle2), 32'h1);
    adv_to(631);
    check("flk_stop1", 32'(stopped2), 32'h1);
    obj2 = 1'b0;
    adv_to(660);
    check("flk_obst0", 32'(obstacle2), 32'h0);
    adv_to(661);
    obj2 = 1'b1;
    for (int n = 662; n <= 700; n++) begin
      adv_to(n);
      check("flk_motor", 32'(motor2), 32'h0);
      check("flk_stopped", 32'(stopped2), 32'h1);
      if (n == 690) check("flk_obst_re", 32'(obstacle2), 32'h1);
    end
    adv_to(760);
    check("flk_acc_early", 32'(blocked2), 32'h0);
    adv_to(761);
    check("flk_acc_blocked", 32'(blocked2), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
